// File: rtl/modarith_pkg.sv
// Shared types and default sizes for the modular add/sub datapath.
package modarith_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_LANES = 4;
  localparam int DEF_TAG_W = 4;

endpackage

// File: rtl/mod_addsub_pipe_if.sv
// Input and output stream of the modular add/sub unit, valid/ready on both sides.
interface mod_addsub_pipe_if
  import modarith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int TAG_W = DEF_TAG_W
);
  logic                   in_valid;
  logic                   in_ready;
  mode_e                  in_mode;
  logic [WIDTH-1:0]       in_p;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_r;
  logic [TAG_W-1:0]       out_tag;
  logic [LANES-1:0]       out_range_err;

  modport master (
    output in_valid, in_mode, in_p, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_tag, out_range_err
  );

  modport slave (
    input  in_valid, in_mode, in_p, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_tag, out_range_err
  );
endinterface

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/sub: S1 forms the raw WIDTH+1-bit sum/difference,
// S2 applies the single conditional correction by p.
module mod_addsub_lane
  import modarith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en1,
  input  logic             en2,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] p_s1,
  input  mode_e            mode_s1,
  output logic [WIDTH-1:0] r,
  output logic             range_err
);

  logic [WIDTH:0]   t1;
  logic             err1;
  logic [WIDTH-1:0] corr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t1   <= '0;
      err1 <= 1'b0;
    end else if (en1) begin
      t1   <= (mode == MODE_SUB) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      err1 <= (a >= p) || (b >= p);
    end
  end

  // The add compare needs the carry bit; t1[WIDTH] is the borrow in sub mode.
  always_comb begin
    corr = t1[WIDTH-1:0];
    if (mode_s1 == MODE_SUB) begin
      if (t1[WIDTH]) corr = t1[WIDTH-1:0] + p_s1;
    end else begin
      if (t1 >= {1'b0, p_s1}) corr = t1[WIDTH-1:0] - p_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r         <= '0;
      range_err <= 1'b0;
    end else if (en2) begin
      r         <= corr;
      range_err <= err1;
    end
  end

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage pipelined modular add/sub over LANES lanes sharing one modulus,
// with valid/ready flow control and a pass-through tag.
module mod_addsub_pipe
  import modarith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES,
  parameter int TAG_W = DEF_TAG_W
) (
  input logic               clk,
  input logic               rst_n,
  mod_addsub_pipe_if.slave  bus
);

  logic             v1, v2;
  logic             adv1, adv2;
  logic             acc, en2;
  logic [TAG_W-1:0] tag1;
  logic [WIDTH-1:0] p1;
  mode_e            mode1;
  logic [WIDTH-1:0] r_lane [LANES];
  logic [LANES-1:0] err_lane;

  // in_ready is gated by rst_n so nothing is accepted while reset is held.
  assign adv2         = !v2 || bus.out_ready;
  assign adv1         = !v1 || adv2;
  assign bus.in_ready = rst_n && adv1;
  assign acc          = bus.in_valid && bus.in_ready;
  assign en2          = adv2 && v1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      tag1        <= '0;
      p1          <= '0;
      mode1       <= MODE_ADD;
      bus.out_tag <= '0;
    end else begin
      if (adv1) v1 <= bus.in_valid;
      if (acc) begin
        tag1  <= bus.in_tag;
        p1    <= bus.in_p;
        mode1 <= bus.in_mode;
      end
      if (adv2) v2 <= v1;
      if (en2) bus.out_tag <= tag1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mod_addsub_lane #(.WIDTH(WIDTH)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en1       (acc),
      .en2       (en2),
      .a         (bus.in_a[i*WIDTH +: WIDTH]),
      .b         (bus.in_b[i*WIDTH +: WIDTH]),
      .p         (bus.in_p),
      .mode      (bus.in_mode),
      .p_s1      (p1),
      .mode_s1   (mode1),
      .r         (r_lane[i]),
      .range_err (err_lane[i])
    );
  end

  always_comb begin
    bus.out_r = '0;
    for (int i = 0; i < LANES; i++) bus.out_r[i*WIDTH +: WIDTH] = r_lane[i];
  end

  assign bus.out_valid     = v2;
  assign bus.out_range_err = err_lane;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Bench for mod_addsub_pipe: directed and random beats against a modular-arithmetic
// reference with an in-order scoreboard and randomized backpressure.
module tb_mod_addsub_pipe;
  import modarith_pkg::*;

  localparam int W  = 32;
  localparam int L  = 4;
  localparam int TW = 4;
  localparam int CW = L*W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_addsub_pipe_if #(.WIDTH(W), .LANES(L), .TAG_W(TW)) bus ();

  mod_addsub_pipe #(.WIDTH(W), .LANES(L), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [CW-1:0] r;
    logic [TW-1:0] tag;
    logic [L-1:0]  err;
    int            acc_cyc;
  } exp_t;

  exp_t q[$];
  int n_vec = 0, n_bad = 0, cyc = 0, n_out = 0;
  bit chk_lat = 0, acc_last = 0, stalled_prev = 0;
  logic [CW-1:0] held_r;
  logic [TW-1:0] held_tag;
  logic [L-1:0]  held_err;

  logic [W-1:0]  ca [L];
  logic [W-1:0]  cb [L];
  logic [W-1:0]  cur_p;
  bit            cur_sub;
  logic [TW-1:0] cur_tag;

  // Reference: true modular result for legal operands; raw formula otherwise.
  function automatic logic [W-1:0] ref_r(longint unsigned a, longint unsigned b,
                                         longint unsigned p, bit sub);
    longint unsigned m = 64'h1_0000_0000;
    if (p != 0 && a < p && b < p) return W'(sub ? (a + p - b) % p : (a + b) % p);
    if (!sub) return W'((a + b >= p) ? a + b - p : a + b);
    return W'((a >= b) ? a - b : (a + m - b + p) % m);
  endfunction

  task automatic chk(string tag, logic [CW-1:0] obs, logic [CW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v);
    bus.in_valid = v;
    bus.in_mode  = cur_sub ? MODE_SUB : MODE_ADD;
    bus.in_p     = cur_p;
    bus.in_tag   = cur_tag;
    for (int i = 0; i < L; i++) begin
      bus.in_a[i*W +: W] = ca[i];
      bus.in_b[i*W +: W] = cb[i];
    end
  endtask

  task automatic rand_beat(logic [TW-1:0] tag);
    cur_p = $urandom;
    if (cur_p == 0) cur_p = 1;
    if ($urandom_range(0, 3) == 0) cur_p = W'($urandom_range(1, 40));
    for (int i = 0; i < L; i++) begin
      ca[i] = $urandom % cur_p;
      cb[i] = $urandom % cur_p;
    end
    cur_sub = 1'($urandom % 2);
    cur_tag = tag;
    drive(1'b1);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc_last = 0;
    if (rst_n) begin
      if (stalled_prev) begin
        chk("hold_r",   bus.out_r,               held_r);
        chk("hold_tag", CW'(bus.out_tag),        CW'(held_tag));
        chk("hold_err", CW'(bus.out_range_err),  CW'(held_err));
      end
      chk("in_ready", CW'(bus.in_ready), CW'(!(q.size() == 2 && !bus.out_ready)));
      if (q.size() == 0) begin
        chk("idle_valid", CW'(bus.out_valid), CW'(0));
      end else if (bus.out_valid && bus.out_ready) begin
        e = q.pop_front();
        chk("out_r",   bus.out_r,              e.r);
        chk("out_tag", CW'(bus.out_tag),       CW'(e.tag));
        chk("out_err", CW'(bus.out_range_err), CW'(e.err));
        if (chk_lat) chk("latency", CW'(cyc - e.acc_cyc), CW'(2));
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int i = 0; i < L; i++) begin
          e.r[i*W +: W] = ref_r(ca[i], cb[i], cur_p, cur_sub);
          e.err[i]      = (ca[i] >= cur_p) || (cb[i] >= cur_p);
        end
        e.tag     = cur_tag;
        e.acc_cyc = cyc;
        q.push_back(e);
        acc_last = 1;
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      held_r   = bus.out_r;
      held_tag = bus.out_tag;
      held_err = bus.out_range_err;
    end else begin
      q.delete();
      stalled_prev = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string tag);
    int k = 0;
    drive(1'b0);
    bus.out_ready = 1'b1;
    while (q.size() != 0 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, CW'(q.size()), CW'(0));
  endtask

  initial begin
    int base, sent, guard;
    bit need_new;

    // Reset held with a valid beat presented
    cur_p = 32'd13; cur_sub = 0; cur_tag = '0;
    for (int i = 0; i < L; i++) begin ca[i] = W'(i); cb[i] = W'(i + 1); end
    drive(1'b1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_out_valid", CW'(bus.out_valid), CW'(0));
      chk("rst_out_r",     bus.out_r,          CW'(0));
      chk("rst_in_ready",  CW'(bus.in_ready),  CW'(0));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    drive(1'b0);
    tick();

    // Add with carry past 32 bits, a=b=p-1, zeros, a+b==p
    cur_p = 32'hFB801FF3; cur_sub = 0; cur_tag = 4'd1;
    ca[0] = 32'hFB801FF2; cb[0] = 32'hFB801F32;
    ca[1] = cur_p - 1;    cb[1] = cur_p - 1;
    ca[2] = '0;           cb[2] = '0;
    ca[3] = 32'd1;        cb[3] = cur_p - 1;
    drive(1'b1);
    tick();

    // Subtract wrap with p=13
    cur_p = 32'd13; cur_sub = 1; cur_tag = 4'd2;
    ca[0] = 5; cb[0] = 7;
    ca[1] = 7; cb[1] = 5;
    ca[2] = 4; cb[2] = 4;
    ca[3] = 0; cb[3] = 12;
    drive(1'b1);
    tick();
    drain("directed_drain");

    // Back-to-back stream with fixed latency
    base = n_out;
    chk_lat = 1;
    for (int t = 0; t < 16; t++) begin
      rand_beat(TW'(t));
      tick();
    end
    drain("stream_drain");
    chk_lat = 0;
    chk("stream_count", CW'(n_out - base), CW'(16));

    // Random backpressure over 32 beats
    base = n_out; sent = 0; guard = 0; need_new = 1;
    while (sent < 32 && guard < 2000) begin
      if (need_new) begin
        rand_beat(TW'(sent));
        need_new = 0;
      end
      bus.out_ready = 1'($urandom % 2);
      tick();
      if (acc_last) begin
        sent++;
        need_new = 1;
      end
      guard++;
    end
    chk("bp_sent", CW'(sent), CW'(32));
    drain("bp_drain");
    chk("bp_count", CW'(n_out - base), CW'(32));

    // Out-of-range operands and p=0
    cur_p = 32'd13; cur_sub = 0; cur_tag = 4'd5;
    ca[0] = 13; cb[0] = 1;
    ca[1] = 14; cb[1] = 0;
    ca[2] = 0;  cb[2] = 13;
    ca[3] = 12; cb[3] = 12;
    drive(1'b1);
    tick();
    cur_p = '0; cur_sub = 1; cur_tag = 4'd6;
    for (int i = 0; i < L; i++) begin ca[i] = $urandom; cb[i] = $urandom; end
    drive(1'b1);
    tick();
    drain("range_drain");

    // Reset pulse with two beats in flight: neither may ever appear
    bus.out_ready = 1'b0;
    rand_beat(4'd9);
    tick();
    rand_beat(4'd10);
    tick();
    chk("inflight_count", CW'(q.size()), CW'(2));
    drive(1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
Parametrised, pipelined modular add/subtract unit for the coprocessor's RNS/NTT datapath. It is the successor to the combinational modular adder. It processes LANES coefficient pairs per beat against one shared modulus, and supports a per-beat add/sub mode and a full valid/ready handshake with backpressure. It sits between the coefficient memory read path and the NTT butterfly/accumulate stages.

Parameters:
WIDTH, 32, coefficient and modulus width in bits
LANES, 4, independent lanes per beat, all sharing in_p and in_mode
TAG_W, 4, width of the opaque sideband tag carried alongside each beat

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset; synchronous and active-low
in_valid  input  1  input beat valid
in_ready  output  1  unit can accept a beat this cycle
in_mode  input  1  0 = (a+b) mod p, 1 = (a-b) mod p
in_p  input  WIDTH  modulus, shared by all lanes of the beat
in_a  input  LANES*WIDTH  operand A, lane i at bits [i*WIDTH +: WIDTH]
in_b  input  LANES*WIDTH  operand B, same packing as in_a
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts the result
out_r  output  LANES*WIDTH  results, same lane packing as the inputs
out_tag  output  TAG_W  tag of the beat
out_range_err  output  LANES  per lane: a>=p or b>=p at input

Behaviour:
- One clock domain. Reset is synchronous and active-low, sampled on the clk rising edge.
- While rst_n=0 every register clears: stage valids, out_valid, out_r, out_tag and out_range_err all go to 0. in_ready=0 during reset.
- A reset asserted mid-operation discards all in-flight beats; no partial output appears.
- Transfer happens when valid&&ready are high on the same edge. This holds on both sides.
- Two pipeline stages, S1 and S2. S2 is the output register.
- adv2 = !v2 || out_ready; adv1 = !v1 || adv2; in_ready = adv1 (combinational; out_ready→in_ready path allowed).
- Latency is 2 cycles from input accept to out_valid when out_ready is held high. Throughput is 1 beat per cycle with no bubbles.
- Backpressure: while out_valid=1 and out_ready=0, out_r, out_tag and out_range_err hold stable. S1 holds too if it is full.
- S1 per lane, using WIDTH+1-bit arithmetic with no truncation:
  - add: t = a + b
  - sub: t = a - b, with borrow bit kept
  - S1 also registers p, mode, tag and range_err.
- S2 correction per lane:
  - add: r = (t >= p) ? t - p : t. The compare is done at WIDTH+1 bits, so a carry-out beyond WIDTH bits is handled.
  - sub: r = borrow ? t + p : t, truncated to WIDTH.
- Valid operands (a<p, b<p, p>=1) always give 0 <= r < p.
- Out-of-range operands: the formula is applied as-is and the lane's out_range_err=1. The unit does not saturate or stall.
- p=0: out_range_err=1 for every lane; r follows the formula.
- Boundary requirements:
  - a=b=0 gives r=0.
  - add with a+b == p gives r=0.
  - sub with a==b gives r=0.
  - sub with a=0, b=p-1 gives r=1.
- Lanes are independent, with no carry between lanes.

Decomposition:
- Package modarith_pkg:
  - mode_e enum (MODE_ADD=1'b0, MODE_SUB=1'b1)
  - default-width localparams
- One sub-module, mod_addsub_lane:
  - the single-lane two-stage datapath
  - inputs: en1, en2, a, b, p, mode
  - outputs: r, range_err
- mod_addsub_pipe owns the handshake/valid control, the tag/p/mode pipeline registers, and a generate loop of LANES instances.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, out_r=0, in_ready=0. Release → in_ready=1.
- Add with 32-bit overflow on lane 0: p=0xFB801FF3, a=0xFB801FF2, b=0xFB801F32, out_ready=1 → 2 cycles later out_r lane0=0xFB801F31, range_err=0. On another lane, a=b=p-1 → p-2=0xFB801FF1.
- Sub wrap, mode=1, p=13: lanes (a,b) = (5,7), (7,5), (4,4), (0,12) → lanes 11, 2, 0, 1.
- Streaming: 16 back-to-back random in-range beats, in-order tags 0..15, out_ready=1 → outputs on 16 consecutive cycles starting 2 cycles after the first accept. Tags are in order and every result matches the reference model (a±b) mod p.
- Backpressure: toggle out_ready with a random 50% pattern during a 32-beat stream. Required:
  - no beat lost or duplicated;
  - out_r stable while stalled;
  - in_ready low only when both stages are full and out_ready=0.
- Range error and mid-stream reset:
  - a=13, b=1, p=13 → out_range_err lane bit = 1.
  - Pulse rst_n=0 for 1 cycle with two beats in flight → out_valid=0 the next cycle, and neither in-flight beat is ever emitted.
